uart_tx_seq: RTL

- Frame sequencer and 8N1 serializer that sits directly downstream of the 4:1 byte multiplexer.
- Drives the mux select, captures the selected byte and shifts it out on the UART TX line.
- Sends bytes 0..NUM_BYTES-1 back-to-back in one burst per start request, then signals completion.
- Mux is purely combinational, so din is valid in the same cycle sel is stable.

---
 rtl/uart_tx_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_seq.sv
// uart_tx_seq: walks the byte mux through select values 0..NUM_BYTES-1,
// captures each selected byte and serialises it as an 8N1 frame on tx.
// One burst per accepted start; done pulses for the first idle cycle after it.
module uart_tx_seq #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic [1:0] sel,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    LAST_IDX = 2'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [1:0]    idx_r, idx_s;
    logic [2:0]    bit_r, bit_s;
    logic [CW-1:0] baud_r, baud_s;
    logic [7:0]    shift_r, shift_s;
    logic [1:0]    sel_r, sel_s;
    logic          tx_r, tx_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          baud_end_s;

    // State, datapath and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            idx_r   <= 2'd0;
            bit_r   <= 3'd0;
            baud_r  <= '0;
            shift_r <= 8'd0;
            sel_r   <= 2'd0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            bit_r   <= bit_s;
            baud_r  <= baud_s;
            shift_r <= shift_s;
            sel_r   <= sel_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; output registers are loaded from the values of the next state.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        bit_s      = bit_r;
        baud_s     = baud_r;
        shift_s    = shift_r;
        sel_s      = sel_r;
        done_s     = 1'b0;
        baud_end_s = (baud_r == BAUD_MAX);

        case (state_r)
            S_IDLE: begin
                sel_s = 2'd0;
                if (start) begin
                    state_s = S_LOAD;
                    idx_s   = 2'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                // sel already points at idx_r, so din is the byte to send
                shift_s = din;
                baud_s  = '0;
                bit_s   = 3'd0;
                state_s = S_START;
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_s  = '0;
                    state_s = S_DATA;
                end else begin
                    baud_s  = baud_r + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_s  = '0;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        state_s = S_STOP;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                    end
                end else begin
                    baud_s  = baud_r + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_s = '0;
                    if (idx_r == LAST_IDX) begin
                        state_s = S_IDLE;
                        idx_s   = 2'd0;
                        sel_s   = 2'd0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = S_LOAD;
                        idx_s   = idx_r + 2'd1;
                        sel_s   = idx_r + 2'd1;
                    end
                end else begin
                    baud_s = baud_r + 1'b1;
                end
            end
            default: begin
                state_s = S_IDLE;
                idx_s   = 2'd0;
                bit_s   = 3'd0;
                baud_s  = '0;
                sel_s   = 2'd0;
            end
        endcase

        case (state_s)
            S_START: tx_s = 1'b0;
            S_DATA:  tx_s = shift_s[0];
            default: tx_s = 1'b1;
        endcase
        busy_s = (state_s != S_IDLE);
    end

    assign sel  = sel_r;
    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
